piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register that serialises one N-bit word per transaction onto a single-bit line.
- It is the transmit side of a serial link: the matching receiver shifts bits in and presents them to a parallel D register.
- Parallel load uses a valid/ready handshake. The serial side is a bit plus a qualifying valid, with a one-cycle done pulse on the last bit.
- Back-to-back words stream with no idle gap.

Parameters:
- N, 4: data word width in bits; must be at least 2.
- MSB_FIRST, 1: 1 sends bit N-1 first; 0 sends bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load_valid  input  1  producer has a word on load_data.
- load_data  input  N  word to serialise; sampled only on handshake.
- load_ready  output  1  block can accept a word this cycle (combinational).
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out carries a valid bit (registered).
- busy  output  1  high while a word is being shifted (registered).
- done  output  1  one-cycle pulse, high during the final bit of a word (registered).

Behaviour:
- Reset is asynchronous: reset_n low forces state IDLE immediately.
  - Outputs: ser_out=0, ser_valid=0, busy=0, done=0.
  - Internal state: shift register=0, bit counter=0.
  - load_ready=1 in IDLE, including while reset is held. Handshakes are not honoured while reset_n=0.
- A transfer is accepted on a rising edge where load_valid && load_ready.
- State machine:
  - IDLE: load_ready=1. On accept, capture load_data, set counter=BITS-1, and go to SHIFT.
  - SHIFT, counter>0: load_ready=0. Each edge shifts one bit out and decrements the counter.
  - SHIFT, counter==0 (last bit): load_ready=1.
    - On accept: reload and stay in SHIFT. The first bit of the new word follows the last bit of the old word with no gap.
    - Without accept: go to IDLE.
- BITS is N, or N+1 when parity is enabled.
- Latency:
  - Word accepted at edge k: the first bit is on ser_out during cycle k+1 and the last bit during cycle k+BITS.
  - ser_valid=1 and busy=1 for exactly BITS cycles per word.
  - done=1 in cycle k+BITS only.
- Bit order:
  - MSB_FIRST=1: bit N-1 first, down to bit 0.
  - MSB_FIRST=0: bit 0 first, up to bit N-1.
- When ser_valid=0, ser_out is driven 0.
- load_data changes while load_ready=0 are ignored. A captured word is never modified.
- load_valid held high continuously gives an uninterrupted bit stream, with one done pulse per word.
- Reset mid-word:
  - Shifting aborts immediately and the partial word is discarded.
  - No done pulse is issued.
  - After reset_n rises, the block is in IDLE and ready.
- Counter width is $clog2(N+2) bits and never wraps below 0. The transition on counter==0 is decisive.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An even-parity bit, the XOR of all N captured data bits, is sent as bit BITS=N+1 after the data bits, in either bit order.
  - done and the back-to-back reload point coincide with the parity bit cycle.
- Undefined: BITS=N, and no parity logic is present.

Decomposition:
- Shared package piso_pkg:
  - State encoding: IDLE=1'b0, SHIFT=1'b1.
  - Counter-width function clog2-based.
  - Constant PARITY_BITS (1 or 0 per the macro).
- Natural sub-module: piso_bit_counter.
  - Loadable down-counter with load, enable, and a last flag at zero.
  - Instantiated once; the FSM and shift register stay in the top level.

Test Plan (N=4 unless noted):
- Reset then single word:
  - Stimulus: load 4'b1011 with MSB_FIRST=1.
  - Response: ser_out 1,0,1,1 on four consecutive cycles starting one cycle after accept; ser_valid high for exactly 4 cycles; done high only on the 4th.
- LSB first:
  - Stimulus: MSB_FIRST=0, load 4'b1011.
  - Response: ser_out 1,1,0,1.
- Back-to-back:
  - Stimulus: load_valid held high with 4'hA then 4'h5.
  - Response: 8 contiguous valid bits 1,0,1,0,0,1,0,1; load_ready high on cycles 4 and 8 only; two done pulses; busy never drops between words.
- Stall:
  - Stimulus: load_valid low after one word.
  - Response: IDLE after the last bit; ser_valid=0, ser_out=0, load_ready=1.
- Reset mid-word:
  - Stimulus: reset_n low after 2 bits of 4'hF.
  - Response: ser_valid, busy and done go to 0 immediately; no done pulse; the next word 4'h3 serialises correctly.
- PISO_PARITY_EN defined:
  - Stimulus: load 4'b1011.
  - Response: 5 bits 1,0,1,1,1; done on the 5th bit. Loading 4'b1001 gives a final parity bit of 0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
// Optional build macro: PISO_PARITY_EN appends an even-parity bit to every word.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Wide enough to hold BITS-1 for the parity build as well.
    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/piso_shift_register_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of the word on the line.
// It saturates at zero and flags the last bit.
module piso_bit_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             last
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == '0);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register with a valid/ready load port.
// Optional build macro: PISO_PARITY_EN sends an even-parity bit after the data bits.
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int N         = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_valid,
    input  logic [N-1:0] load_data,
    output logic         load_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         busy,
    output logic         done
);

    localparam int BITS  = N + PARITY_BITS;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(BITS - 1);

    state_t         state_d, state_q;
    logic [N-1:0]   shift_d, shift_q;
    logic           ser_out_d, ser_out_q;
    logic           ser_valid_d, ser_valid_q;
    logic           busy_d, busy_q;
    logic           done_d, done_q;
    logic           cnt_load, cnt_en, cnt_last;
    logic [CNT_W-1:0] cnt;
    logic           accept;
`ifdef PISO_PARITY_EN
    logic           parity_d, parity_q;
`endif

    piso_bit_counter #(.WIDTH(CNT_W)) u_bit_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (FIRST_CNT),
        .enable     (cnt_en),
        .count      (cnt),
        .last       (cnt_last)
    );

    // Ready in IDLE and on the last bit, so a new word can follow without a gap.
    assign load_ready = (state_q == IDLE) || cnt_last;
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d    = parity_q;
`endif
        if (accept) begin
            state_d     = SHIFT;
            cnt_load    = 1'b1;
            ser_valid_d = 1'b1;
            busy_d      = 1'b1;
            if (MSB_FIRST != 0) begin
                ser_out_d = load_data[N-1];
                shift_d   = {load_data[N-2:0], 1'b0};
            end else begin
                ser_out_d = load_data[0];
                shift_d   = {1'b0, load_data[N-1:1]};
            end
`ifdef PISO_PARITY_EN
            parity_d    = ^load_data;
`endif
        end else if (state_q == SHIFT) begin
            if (cnt_last) begin
                state_d = IDLE;
            end else begin
                cnt_en      = 1'b1;
                ser_valid_d = 1'b1;
                busy_d      = 1'b1;
                done_d      = (cnt == CNT_W'(1));
                if (MSB_FIRST != 0) begin
                    ser_out_d = shift_q[N-1];
                    shift_d   = {shift_q[N-2:0], 1'b0};
                end else begin
                    ser_out_d = shift_q[0];
                    shift_d   = {1'b0, shift_q[N-1:1]};
                end
`ifdef PISO_PARITY_EN
                if (cnt == CNT_W'(1)) begin
                    ser_out_d = parity_q;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PISO_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench: one MSB-first and one LSB-first instance share the same stimulus,
// driven from a per-cycle vector table plus a continuous-streaming sequence.
module tb_piso_shift_register;

    localparam int N = 4;
`ifdef PISO_PARITY_EN
    localparam int BITS = N + 1;
`else
    localparam int BITS = N;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [N-1:0] load_data = '0;

    logic ready_m, ser_m, valid_m, busy_m, done_m;
    logic ready_l, ser_l, valid_l, busy_l, done_l;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         rst_n;
        logic         lv;
        logic [N-1:0] data;
        logic         exp_msb;
        logic         exp_lsb;
        logic         exp_act;
        logic         exp_done;
        logic         exp_ready;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    piso_shift_register #(.N(N), .MSB_FIRST(1)) dut_msb (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (ready_m),
        .ser_out    (ser_m),
        .ser_valid  (valid_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_shift_register #(.N(N), .MSB_FIRST(0)) dut_lsb (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (ready_l),
        .ser_out    (ser_l),
        .ser_valid  (valid_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    task automatic check(input string name, input int idx, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s row %0d: got %b, want %b", name, idx, actual, expected);
        end
    endtask

    task automatic add(input logic rst_n, input logic lv, input logic [N-1:0] data,
                       input logic msb, input logic lsb, input logic act,
                       input logic dn, input logic rdy);
        vec_t v;
        v.rst_n = rst_n; v.lv = lv; v.data = data;
        v.exp_msb = msb; v.exp_lsb = lsb; v.exp_act = act;
        v.exp_done = dn; v.exp_ready = rdy;
        vecs.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        reset_n    = v.rst_n;
        load_valid = v.lv;
        load_data  = v.data;
        #1;
    endtask

    task automatic check_output(input vec_t v, input int idx);
        check("ser_out_msb",   idx, ser_m,   v.exp_msb);
        check("ser_out_lsb",   idx, ser_l,   v.exp_lsb);
        check("ser_valid_msb", idx, valid_m, v.exp_act);
        check("ser_valid_lsb", idx, valid_l, v.exp_act);
        check("busy_msb",      idx, busy_m,  v.exp_act);
        check("busy_lsb",      idx, busy_l,  v.exp_act);
        check("done_msb",      idx, done_m,  v.exp_done);
        check("done_lsb",      idx, done_l,  v.exp_done);
        check("ready_msb",     idx, ready_m, v.exp_ready);
        check("ready_lsb",     idx, ready_l, v.exp_ready);
    endtask

    initial begin
        int accepts, dones, vcount, first, last;
        bit finished;

        // Columns: rst_n, load_valid, load_data, exp msb-first bit, exp lsb-first bit,
        // exp valid/busy, exp done, exp load_ready. Edge follows each row's check.
`ifdef PISO_PARITY_EN
        add(0, 0, 4'h0, 0, 0, 0, 0, 1);
        add(1, 1, 4'hB, 0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 1, 1);
        add(1, 1, 4'hA, 0, 0, 0, 0, 1);
        add(1, 1, 4'h9, 1, 0, 1, 0, 0);
        add(1, 1, 4'h9, 0, 1, 1, 0, 0);
        add(1, 1, 4'h9, 1, 0, 1, 0, 0);
        add(1, 1, 4'h9, 0, 1, 1, 0, 0);
        add(1, 1, 4'h9, 0, 0, 1, 1, 1);
        add(1, 0, 4'hF, 1, 1, 1, 0, 0);
        add(1, 0, 4'hF, 0, 0, 1, 0, 0);
        add(1, 0, 4'hF, 0, 0, 1, 0, 0);
        add(1, 0, 4'hF, 1, 1, 1, 0, 0);
        add(1, 0, 4'hF, 0, 0, 1, 1, 1);
        add(1, 0, 4'h0, 0, 0, 0, 0, 1);
        add(1, 1, 4'hF, 0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(0, 1, 4'h3, 0, 0, 0, 0, 1);
        add(1, 1, 4'h3, 0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 1, 0, 0);
        add(1, 0, 4'h0, 0, 0, 1, 1, 1);
        add(1, 0, 4'h0, 0, 0, 0, 0, 1);
`else
        add(0, 0, 4'h0, 0, 0, 0, 0, 1);
        add(1, 1, 4'hB, 0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 1, 1);
        add(1, 1, 4'hA, 0, 0, 0, 0, 1);
        add(1, 1, 4'h5, 1, 0, 1, 0, 0);
        add(1, 1, 4'h5, 0, 1, 1, 0, 0);
        add(1, 1, 4'h5, 1, 0, 1, 0, 0);
        add(1, 1, 4'h5, 0, 1, 1, 1, 1);
        add(1, 0, 4'hF, 0, 1, 1, 0, 0);
        add(1, 0, 4'hF, 1, 0, 1, 0, 0);
        add(1, 0, 4'hF, 0, 1, 1, 0, 0);
        add(1, 0, 4'hF, 1, 0, 1, 1, 1);
        add(1, 1, 4'hF, 0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 1, 1, 0, 0);
        add(0, 1, 4'h3, 0, 0, 0, 0, 1);
        add(1, 1, 4'h3, 0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 0, 1, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 1, 0, 0);
        add(1, 0, 4'h0, 1, 0, 1, 1, 1);
        add(1, 0, 4'h0, 0, 0, 0, 0, 1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // Hold load_valid high for three words: expect one unbroken bit stream.
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 4'h6;
        accepts = 0; dones = 0; vcount = 0; first = -1; last = -1;
        finished = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc != 0) @(negedge clk);
            if (accepts == 3) load_valid = 1'b0;
            #1;
            if (valid_m) begin
                vcount++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (done_m) dones++;
            if (load_valid && ready_m) accepts++;
            if (accepts == 3 && !load_valid && !busy_m) begin
                finished = 1'b1;
                break;
            end
        end
        check("stream_finished", 0, finished, 1'b1);
        total++;
        if (dones != 3) begin
            bad++;
            $display("[TB] FAIL stream_done_count: got %0d, want 3", dones);
        end
        total++;
        if (vcount != 3 * BITS) begin
            bad++;
            $display("[TB] FAIL stream_valid_cycles: got %0d, want %0d", vcount, 3 * BITS);
        end
        total++;
        if (last - first + 1 != vcount) begin
            bad++;
            $display("[TB] FAIL stream_contiguous: span %0d, valid cycles %0d", last - first + 1, vcount);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
